uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
Parametrised UART frame transmitter. It accepts a DATA_BYTES-wide payload through a valid/ready handshake and wraps it in a fixed frame: two sync bytes, the payload MSB-first, an optional 8-bit checksum, and an end byte. It serialises the frame as 8N1 on tx using an internal baud divider, so no external transmitter instance is needed. It sits between measurement/TDC result logic and the board UART pin.

Parameters:
CLK_HZ, 20000000, system clock frequency in Hz
BAUD, 500000, line rate in bit/s; DIV = CLK_HZ/BAUD (integer, >=2; default 40)
DATA_BYTES, 3, payload bytes per frame (1..16)
SYNC0, 8'h7B, first header byte
SYNC1, 8'h7C, second header byte
END_BYTE, 8'h7E, trailer byte
CSUM_EN, 1, 1 = insert checksum byte before END_BYTE; 0 = omit it

Ports:
clk_20m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data  in  8*DATA_BYTES  payload; the most significant byte is sent first
data_valid  in  1  payload valid
data_ready  out  1  high when a payload can be accepted (IDLE only)
tx  out  1  serial output, idle high
busy  out  1  high from capture until the stop bit of END_BYTE completes
frame_done  out  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset (async assert, sync deassert internally): tx=1, data_ready=1, busy=0, frame_done=0, state=IDLE, counters=0, checksum=0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- Capture: on the rising edge with data_valid&&data_ready, latch data into the shift buffer. On the same edge, data_ready becomes 0 and busy becomes 1. data_valid is ignored when data_ready=0; the upstream block must hold data_valid until it is accepted.
- Frame byte order: SYNC0, SYNC1, data[8*DATA_BYTES-1 -: 8] ... data[7:0], [CSUM], END_BYTE. NBYTES = DATA_BYTES+3+CSUM_EN.
- Checksum: 8-bit sum modulo 256 of the payload bytes only. Accumulate it as each payload byte is loaded. Overflow wraps silently.
- Byte states: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD if more bytes, else DONE) -> IDLE.
  - LOAD: takes 0 cycles of line time (combinational select of the next byte). The first start bit is driven on the cycle after capture.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each DIV cycles.
  - STOP: tx=1 for DIV cycles.
  - No inter-byte gap: the next start bit follows the stop bit directly.
- Baud counter: counts 0..DIV-1 and is reloaded at every bit boundary. The bit index counts 0..7. The byte index counts 0..NBYTES-1, with no wrap past NBYTES-1.
- DONE: lasts one cycle. In it, frame_done=1, busy falls to 0 and data_ready rises to 1. The next capture is possible on the following edge.
- Frame length = NBYTES*10*DIV cycles from the first start-bit cycle to the end of the last stop bit. Default: 7*10*40 = 2800 cycles.
- data_valid held high continuously: frames go back-to-back with exactly 2 idle-high cycles between them (DONE plus the capture cycle).
- Changes to data after capture do not affect the frame in flight.
- Elaboration error if DIV<2 or DATA_BYTES is outside 1..16.

Test Plan:
- Reset then data=24'h123456, one-cycle valid -> tx bytes 7B 7C 12 34 56 9C 7E. The first start bit begins 1 cycle after capture. Each bit lasts 40 cycles. frame_done pulses at cycle 2800 after the start. tx, busy and data_ready are correct throughout.
- Bit order check on 0x7B -> after the start bit (0), the line reads 1,1,0,1,1,1,1,0, then stop 1.
- Checksum wrap: data=24'hFFFFFF -> checksum byte 0xFD. With CSUM_EN=0, the same data gives 7B 7C FF FF FF 7E and frame_done at 2400 cycles.
- Back-to-back: valid held high with data 24'hA5A5A5, changed to 24'h010203 one cycle after the first capture -> the first frame carries A5 A5 A5 (csum EF). The second frame carries 01 02 03 (csum 06) and starts exactly 2 cycles after the first frame's end.
- Valid during busy: pulse valid with 24'h000001 mid-frame -> ignored, and the frame in flight is unchanged.
- Reset mid-frame: assert rst_n=0 during the payload byte -> tx=1, busy=0 and data_ready=1 asynchronously. After release, a new capture produces a complete, correct frame.

Source files
------------

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: captures a DATA_BYTES payload on a valid/ready
// handshake and sends SYNC0, SYNC1, payload (MSB byte first), an optional
// 8-bit payload checksum and END_BYTE as 8N1 using an internal baud divider.
module uart_frame_tx #(
  parameter int          CLK_HZ     = 20000000,
  parameter int          BAUD       = 500000,
  parameter int          DATA_BYTES = 3,
  parameter logic [7:0]  SYNC0      = 8'h7B,
  parameter logic [7:0]  SYNC1      = 8'h7C,
  parameter logic [7:0]  END_BYTE   = 8'h7E,
  parameter int          CSUM_EN    = 1
) (
  input  logic                    clk_20m,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NBYTES = DATA_BYTES + 3 + CSUM_EN;
  localparam int PW     = 8 * DATA_BYTES;
  localparam int CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW     = $clog2(NBYTES + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_SYNC1 = IW'(1);
  localparam logic [IW-1:0] PAY_FIRST = IW'(2);
  localparam logic [IW-1:0] PAY_LAST  = IW'(DATA_BYTES + 1);
  localparam logic [IW-1:0] CSUM_IDX  = IW'(DATA_BYTES + 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);

  // Byte-level states; selecting the next byte (LOAD) is combinational and
  // folded into the STOP->START transition, so it costs no line time.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (DIV < 2) begin : g_div_check
    $error("uart_frame_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BYTES < 1 || DATA_BYTES > 16) begin : g_bytes_check
    $error("uart_frame_tx: DATA_BYTES must be within 1..16");
  end

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic [2:0]    state_reg;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [IW-1:0] byte_idx;
  logic [7:0]    shift_byte;
  logic [PW-1:0] pay_buf;
  logic [7:0]    csum_reg;
  logic          tx_reg;

  logic          baud_last;
  logic [IW-1:0] nxt_idx;
  logic          nxt_is_payload;
  logic [7:0]    pay_top;
  logic [7:0]    nxt_byte;

  // Reset asserts asynchronously but is released in step with the clock.
  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign baud_last      = (baud_cnt == BAUD_LAST);
  assign nxt_idx        = byte_idx + 1'b1;
  assign nxt_is_payload = (nxt_idx >= PAY_FIRST) && (nxt_idx <= PAY_LAST);
  assign pay_top        = pay_buf[PW-1 -: 8];

  // Pick the byte that follows the current one in the frame.
  always_comb begin
    nxt_byte = END_BYTE;
    if (nxt_idx == IDX_SYNC1)                     nxt_byte = SYNC1;
    else if (nxt_is_payload)                      nxt_byte = pay_top;
    else if (CSUM_EN != 0 && nxt_idx == CSUM_IDX) nxt_byte = csum_reg;
  end

  // Frame sequencer: handshake, baud timing, bit/byte stepping, checksum.
  always_ff @(posedge clk_20m or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg  <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift_byte <= '0;
      pay_buf    <= '0;
      csum_reg   <= '0;
      tx_reg     <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (data_valid) begin
            state_reg  <= S_START;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift_byte <= SYNC0;
            pay_buf    <= data;
            csum_reg   <= '0;
            tx_reg     <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state_reg <= S_DATA;
            tx_reg    <= shift_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + 1'b1;
              shift_byte <= shift_byte >> 1;
              tx_reg     <= shift_byte[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_IDX) begin
              state_reg <= S_DONE;
            end else begin
              byte_idx   <= nxt_idx;
              shift_byte <= nxt_byte;
              state_reg  <= S_START;
              tx_reg     <= 1'b0;
              if (nxt_is_payload) begin
                pay_buf  <= pay_buf << 8;
                csum_reg <= csum_reg + pay_top;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_reg;
  assign data_ready = (state_reg == S_IDLE);
  assign busy       = (state_reg == S_START) || (state_reg == S_DATA) || (state_reg == S_STOP);
  assign frame_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: a line monitor decodes tx into bytes and the
// test tasks compare them against frames queued when stimulus is driven.
module tb_uart_frame_tx;

  localparam int DIV = 40;

  typedef struct {
    logic [7:0] b;
    longint     t;
    bit         ok;
  } rx_t;

  logic        clk;
  logic        rst_n;
  logic [23:0] data;
  logic        valid0, valid1;
  logic        ready0, ready1, tx0, tx1, busy0, busy1, done0, done1;
  logic        use_ch1;
  logic        mon_tx, mon_ready, mon_busy, mon_done;

  longint      cyc;
  int          errors;
  int          checks;
  logic [7:0]  exp_q[$];
  rx_t         rx_q[$];

  uart_frame_tx dut (
    .clk_20m(clk), .rst_n(rst_n), .data(data), .data_valid(valid0),
    .data_ready(ready0), .tx(tx0), .busy(busy0), .frame_done(done0)
  );

  uart_frame_tx #(.CSUM_EN(0)) dut_nocsum (
    .clk_20m(clk), .rst_n(rst_n), .data(data), .data_valid(valid1),
    .data_ready(ready1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  assign mon_tx    = use_ch1 ? tx1    : tx0;
  assign mon_ready = use_ch1 ? ready1 : ready0;
  assign mon_busy  = use_ch1 ? busy1  : busy0;
  assign mon_done  = use_ch1 ? done1  : done0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples each bit mid-way and queues decoded bytes.
  initial begin
    bit         mon_active;
    int         mon_cnt;
    int         bi;
    longint     mon_t;
    bit         mon_ok;
    logic [7:0] mon_b;
    mon_active = 0;
    mon_cnt = 0;
    mon_t = 0;
    mon_ok = 0;
    mon_b = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (mon_tx === 1'b0) begin
          mon_active = 1;
          mon_cnt = 0;
          mon_t = cyc;
          mon_ok = 1;
          mon_b = 8'h00;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % DIV == DIV / 2) begin
          bi = mon_cnt / DIV;
          if (bi == 0) begin
            if (mon_tx !== 1'b0) mon_ok = 0;
          end else if (bi <= 8) begin
            mon_b[bi-1] = mon_tx;
          end else begin
            if (mon_tx !== 1'b1) mon_ok = 0;
            rx_q.push_back('{b: mon_b, t: mon_t, ok: mon_ok});
            mon_active = 0;
          end
        end
      end
    end
  end

  // Queue the bytes a frame carrying d should put on the line.
  task automatic push_frame(input logic [23:0] d, input bit with_csum);
    logic [7:0] sum;
    sum = d[23:16] + d[15:8] + d[7:0];
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'h7C);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    if (with_csum) exp_q.push_back(sum);
    exp_q.push_back(8'h7E);
  endtask

  // One-cycle valid pulse; cap is the first cycle after the capture edge.
  task automatic start_frame(input logic [23:0] d, output longint cap);
    @(negedge clk);
    data = d;
    if (use_ch1) valid1 = 1'b1; else valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    cap = cyc;
  endtask

  task automatic wait_done(output longint d);
    bit got;
    got = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (mon_done === 1'b1) begin
        got = 1;
        break;
      end
    end
    d = cyc;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL frame_done_timeout: got no pulse within 4000 cycles, want one");
    end
  endtask

  // Pop n expected bytes and compare with received bytes and their timing.
  task automatic score_frame(input int n, input longint t0);
    logic [7:0] e;
    rx_t        r;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (exp_q.size() == 0 || rx_q.size() == 0) begin
        errors++;
        $display("FAIL byte%0d_missing: got rx=%0d exp=%0d queued, want both nonzero",
                 k, rx_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front();
        r = rx_q.pop_front();
        if (r.b !== e || !r.ok || r.t != t0 + longint'(k * 10 * DIV)) begin
          errors++;
          $display("FAIL byte%0d: got %02h framing=%0d start=%0d, want %02h framing=1 start=%0d",
                   k, r.b, r.ok, r.t - t0, e, k * 10 * DIV);
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, busy0, ready0, done0, tx1} !== 5'b10101) begin
      errors++;
      $display("FAIL reset_outputs: got tx,busy,ready,done,tx1=%b want 10101",
               {tx0, busy0, ready0, done0, tx1});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({tx0, busy0, ready0} !== 3'b101) begin
      errors++;
      $display("FAIL post_reset_idle: got tx,busy,ready=%b want 101", {tx0, busy0, ready0});
    end
  endtask

  task automatic test_basic_frame;
    longint     cap;
    longint     d;
    logic [9:0] pat;
    logic [9:0] val;
    pat = {1'b1, 8'h7B, 1'b0};
    push_frame(24'h123456, 1'b1);
    @(negedge clk);
    data = 24'h123456;
    valid0 = 1'b1;
    checks++;
    if ({mon_tx, mon_ready} !== 2'b11) begin
      errors++;
      $display("FAIL pre_capture: got tx,ready=%b want 11", {mon_tx, mon_ready});
    end
    @(negedge clk);
    valid0 = 1'b0;
    cap = cyc;
    checks++;
    if ({mon_tx, mon_busy, mon_ready} !== 3'b010) begin
      errors++;
      $display("FAIL first_start_bit: got tx,busy,ready=%b want 010", {mon_tx, mon_busy, mon_ready});
    end
    val = '0;
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (DIV) @(negedge clk);
      val[i] = mon_tx;
    end
    checks++;
    if (val !== pat) begin
      errors++;
      $display("FAIL bit_order_7B: got %b want %b (start..stop, read right to left)", val, pat);
    end
    repeat (2799 - (9 * DIV + DIV / 2)) @(negedge clk);
    checks++;
    if ({mon_tx, mon_busy, mon_done} !== 3'b110) begin
      errors++;
      $display("FAIL last_stop_cycle: got tx,busy,done=%b want 110", {mon_tx, mon_busy, mon_done});
    end
    wait_done(d);
    checks++;
    if (d - cap != 2800 || mon_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_length: got %0d busy=%b want 2800 busy=0", d - cap, mon_busy);
    end
    @(negedge clk);
    checks++;
    if ({mon_ready, mon_done, mon_tx} !== 3'b101) begin
      errors++;
      $display("FAIL after_done: got ready,done,tx=%b want 101", {mon_ready, mon_done, mon_tx});
    end
    score_frame(7, cap);
  endtask

  task automatic test_checksum_wrap;
    longint cap;
    longint d;
    push_frame(24'hFFFFFF, 1'b1);
    start_frame(24'hFFFFFF, cap);
    wait_done(d);
    score_frame(7, cap);
    use_ch1 = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(24'hFFFFFF, 1'b0);
    start_frame(24'hFFFFFF, cap);
    wait_done(d);
    checks++;
    if (d - cap != 2400) begin
      errors++;
      $display("FAIL nocsum_length: got %0d want 2400", d - cap);
    end
    score_frame(6, cap);
    @(negedge clk);
    use_ch1 = 1'b0;
  endtask

  task automatic test_back_to_back;
    longint cap1;
    longint cap2;
    longint d1;
    longint d2;
    bit     got;
    push_frame(24'hA5A5A5, 1'b1);
    push_frame(24'h010203, 1'b1);
    @(negedge clk);
    data = 24'hA5A5A5;
    valid0 = 1'b1;
    @(negedge clk);
    cap1 = cyc;
    data = 24'h010203;
    wait_done(d1);
    checks++;
    if (d1 - cap1 != 2800) begin
      errors++;
      $display("FAIL b2b_first_length: got %0d want 2800", d1 - cap1);
    end
    got = 0;
    cap2 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        got = 1;
        cap2 = cyc;
        break;
      end
    end
    valid0 = 1'b0;
    checks++;
    if (!got || cap2 - d1 != 2) begin
      errors++;
      $display("FAIL b2b_gap: got started=%0d gap=%0d want started=1 gap=2", got, cap2 - d1);
    end
    wait_done(d2);
    checks++;
    if (d2 - cap2 != 2800) begin
      errors++;
      $display("FAIL b2b_second_length: got %0d want 2800", d2 - cap2);
    end
    score_frame(7, cap1);
    score_frame(7, cap2);
  endtask

  task automatic test_valid_during_busy;
    longint cap;
    longint d;
    int     activity;
    push_frame(24'h13579B, 1'b1);
    start_frame(24'h13579B, cap);
    repeat (1000) @(negedge clk);
    data = 24'h000001;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    wait_done(d);
    checks++;
    if (d - cap != 2800) begin
      errors++;
      $display("FAIL busy_valid_length: got %0d want 2800", d - cap);
    end
    activity = 0;
    repeat (60) begin
      @(negedge clk);
      if (mon_tx !== 1'b1 || mon_busy !== 1'b0) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("FAIL busy_valid_ignored: got %0d active cycles after frame want 0", activity);
    end
    score_frame(7, cap);
  endtask

  task automatic test_reset_mid_frame;
    longint cap;
    longint d;
    start_frame(24'hDEADBE, cap);
    repeat (2 * 10 * DIV + 150) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx0, busy0, ready0, done0} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_frame_reset: got tx,busy,ready,done=%b want 1010", {tx0, busy0, ready0, done0});
    end
    repeat (3) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_frame(24'hC0FFEE, 1'b1);
    start_frame(24'hC0FFEE, cap);
    wait_done(d);
    checks++;
    if (d - cap != 2800) begin
      errors++;
      $display("FAIL post_reset_length: got %0d want 2800", d - cap);
    end
    score_frame(7, cap);
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL extra_bytes: got %0d unexpected bytes want 0", rx_q.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    data = '0;
    use_ch1 = 1'b0;
    test_reset();
    test_basic_frame();
    test_checksum_wrap();
    test_back_to_back();
    test_valid_during_busy();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
